// File: rtl/r_alu_seq_decoder.sv
// Sequential LEGv8 ALU decoder: R-type, I-type and multi-cycle MUL instructions to
// registered control words, with a ready/valid intake that stalls during MUL.
module r_alu_seq_decoder #(
    parameter int unsigned DATA_W    = 64,
    parameter int unsigned IMM_W     = 12,
    parameter int unsigned MUL_STEPS = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              instr_valid,
    input  logic [31:0]       instruction,
    output logic              instr_ready,
    output logic              cw_valid,
    output logic [30:0]       controlWord,
    output logic [DATA_W-1:0] K,
    output logic              illegal,
    output logic              busy
);

    localparam int unsigned STEP_W = (MUL_STEPS > 1) ? $clog2(MUL_STEPS) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(MUL_STEPS - 1);

    localparam logic [4:0] FSEL_AND = 5'b00000;
    localparam logic [4:0] FSEL_ORR = 5'b00100;
    localparam logic [4:0] FSEL_EOR = 5'b01100;
    localparam logic [4:0] FSEL_ADD = 5'b01000;
    localparam logic [4:0] FSEL_SUB = 5'b01001;
    localparam logic [4:0] FSEL_MUL = 5'b11000;

    typedef struct packed {
        logic [1:0] psel;
        logic [4:0] da;
        logic [4:0] sa;
        logic [4:0] sb;
        logic [4:0] fsel;
        logic       regw;
        logic       ramw;
        logic       en_mem;
        logic       en_alu;
        logic       en_b;
        logic       en_pc;
        logic       bsel;
        logic       pcsel;
        logic       sl;
    } cw_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_MULT  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic [4:0]         da_q, da_d, sa_q, sa_d, sb_q, sb_d;
    cw_t                cw_q, cw_d;
    logic [DATA_W-1:0]  k_q, k_d;
    logic               cw_valid_q, cw_valid_d;
    logic               illegal_q, illegal_d;
    logic               busy_q, busy_d;

    logic               can_take;
    logic               accept;
    logic               is_r, is_i, is_m;
    logic [4:0]         op_fsel;
    logic               op_sl;
    cw_t                dec_cw;
    logic [DATA_W-1:0]  dec_k;
    logic               dec_illegal;
    cw_t                mul_cw;

    // Opcode bits that no decoded class looks at
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction[31], instruction[22:21]};

    // Intake is open except mid-MUL; the final MUL step overlaps the next accept
    assign can_take    = (state_q != S_MULT) || (step_q == STEP_LAST);
    assign accept      = instr_valid && can_take;
    assign instr_ready = can_take;

    // Class and ALU operation decode of the presented instruction
    always_comb begin
        is_r = ~instruction[28] & instruction[27];
        is_i = instruction[28] & (instruction[27:26] == 2'b00) & ~instruction[23];
        is_m = (instruction[28:27] == 2'b11) & (instruction[25:24] == 2'b11);

        op_fsel = FSEL_AND;
        op_sl   = 1'b0;
        if (instruction[24]) begin
            op_fsel = instruction[30] ? FSEL_SUB : FSEL_ADD;
            op_sl   = instruction[29];
        end else begin
            case (instruction[30:29])
                2'b00:   op_fsel = FSEL_AND;
                2'b01:   op_fsel = FSEL_ORR;
                2'b10:   op_fsel = FSEL_EOR;
                default: op_fsel = FSEL_AND;
            endcase
            op_sl = instruction[30] & instruction[29];
        end

        dec_cw      = '0;
        dec_k       = '0;
        dec_illegal = 1'b0;
        if (is_r || is_i) begin
            dec_cw.psel   = 2'b01;
            dec_cw.da     = instruction[4:0];
            dec_cw.sa     = instruction[9:5];
            dec_cw.sb     = is_r ? instruction[20:16] : 5'd0;
            dec_cw.fsel   = op_fsel;
            dec_cw.regw   = 1'b1;
            dec_cw.en_alu = 1'b1;
            dec_cw.bsel   = is_i;
            dec_cw.sl     = op_sl;
            dec_k = is_r ? DATA_W'(instruction[15:10]) : DATA_W'(instruction[10 +: IMM_W]);
        end else if (is_m) begin
            dec_cw.psel = 2'b00;
            dec_cw.da   = instruction[4:0];
            dec_cw.sa   = instruction[9:5];
            dec_cw.sb   = instruction[20:16];
            dec_cw.fsel = FSEL_MUL;
        end else begin
            // Unsupported: NOP that still advances the PC
            dec_cw.psel = 2'b01;
            dec_illegal = 1'b1;
        end
    end

    // Continuing MUL word built from the fields held since accept
    always_comb begin
        mul_cw      = '0;
        mul_cw.da   = da_q;
        mul_cw.sa   = sa_q;
        mul_cw.sb   = sb_q;
        mul_cw.fsel = FSEL_MUL;
        if (step_d == STEP_LAST) begin
            mul_cw.psel   = 2'b01;
            mul_cw.regw   = 1'b1;
            mul_cw.en_alu = 1'b1;
        end
    end

    // Next state, step counter, held fields and next registered outputs
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        da_d    = da_q;
        sa_d    = sa_q;
        sb_d    = sb_q;

        if ((state_q == S_MULT) && (step_q != STEP_LAST)) begin
            step_d = step_q + STEP_W'(1);
        end else begin
            step_d = '0;
            if (accept) begin
                state_d = is_m ? S_MULT : S_ISSUE;
            end else begin
                state_d = S_IDLE;
            end
        end

        if (accept) begin
            da_d = instruction[4:0];
            sa_d = instruction[9:5];
            sb_d = instruction[20:16];
        end

        cw_d      = '0;
        k_d       = '0;
        illegal_d = 1'b0;
        if (accept) begin
            cw_d      = dec_cw;
            k_d       = dec_k;
            illegal_d = dec_illegal;
        end else if (state_d == S_MULT) begin
            cw_d = mul_cw;
        end

        cw_valid_d = (state_d != S_IDLE);
        busy_d     = (state_d == S_MULT);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            step_q     <= '0;
            da_q       <= '0;
            sa_q       <= '0;
            sb_q       <= '0;
            cw_q       <= '0;
            k_q        <= '0;
            cw_valid_q <= 1'b0;
            illegal_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            da_q       <= da_d;
            sa_q       <= sa_d;
            sb_q       <= sb_d;
            cw_q       <= cw_d;
            k_q        <= k_d;
            cw_valid_q <= cw_valid_d;
            illegal_q  <= illegal_d;
            busy_q     <= busy_d;
        end
    end

    assign controlWord = cw_q;
    assign K           = k_q;
    assign cw_valid    = cw_valid_q;
    assign illegal     = illegal_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_r_alu_seq_decoder.sv
// Scoreboard bench for r_alu_seq_decoder: default instance (MUL_STEPS=4, DATA_W=64)
// plus a short-MUL instance (MUL_STEPS=2, DATA_W=32).
module tb_r_alu_seq_decoder;

    localparam logic [31:0] I_ADD   = 32'h8B030041;
    localparam logic [31:0] I_ADDI  = 32'h910190C5;
    localparam logic [31:0] I_SUBS  = 32'hEB020020;
    localparam logic [31:0] I_MUL   = 32'h9B097D07;
    localparam logic [31:0] I_ORR   = 32'hAA010021;
    localparam logic [31:0] I_LDUR  = 32'hF84003E0;
    localparam logic [31:0] I_ADDIF = 32'h913FFC00;

    typedef struct packed {
        logic [30:0] cw;
        logic [63:0] k;
        logic        ill;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic [31:0] instruction = 32'd0;
    logic        instr_ready, cw_valid, illegal, busy;
    logic [30:0] control_word;
    logic [63:0] k;

    logic        r2_valid = 1'b0;
    logic [31:0] r2_instr = 32'd0;
    logic        r2_ready, r2_cw_valid, r2_illegal, r2_busy;
    logic [30:0] r2_cw;
    logic [31:0] r2_k;

    exp_t sb_q[$];
    exp_t q2[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clock = ~clock;

    r_alu_seq_decoder #(.DATA_W(64), .IMM_W(12), .MUL_STEPS(4)) u_dut (
        .clock(clock), .reset_n(reset_n), .instr_valid(instr_valid),
        .instruction(instruction), .instr_ready(instr_ready), .cw_valid(cw_valid),
        .controlWord(control_word), .K(k), .illegal(illegal), .busy(busy)
    );

    r_alu_seq_decoder #(.DATA_W(32), .IMM_W(12), .MUL_STEPS(2)) u_dut2 (
        .clock(clock), .reset_n(reset_n), .instr_valid(r2_valid),
        .instruction(r2_instr), .instr_ready(r2_ready), .cw_valid(r2_cw_valid),
        .controlWord(r2_cw), .K(r2_k), .illegal(r2_illegal), .busy(r2_busy)
    );

    function automatic logic [30:0] mk(input logic [1:0] psel, input logic [4:0] da,
                                       input logic [4:0] sa, input logic [4:0] sb,
                                       input logic [4:0] fsel, input logic regw,
                                       input logic en_alu, input logic bsel, input logic sl);
        return {psel, da, sa, sb, fsel, regw, 1'b0, 1'b0, en_alu, 1'b0, 1'b0, bsel, 1'b0, sl};
    endfunction

    function automatic exp_t ex(input logic [30:0] cw, input logic [63:0] kv, input logic ill);
        exp_t e;
        e.cw  = cw;
        e.k   = kv;
        e.ill = ill;
        return e;
    endfunction

    // Scoreboard for the default instance: every valid word must match the queue head
    always @(negedge clock) begin
        exp_t e;
        if (reset_n && cw_valid) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_word got cw=%h k=%h ill=%b, no word expected",
                         control_word, k, illegal);
            end else begin
                e = sb_q.pop_front();
                if ({control_word, k, illegal} !== {e.cw, e.k, e.ill}) begin
                    n_fail++;
                    $display("FAIL sb_word got cw=%h k=%h ill=%b expected cw=%h k=%h ill=%b",
                             control_word, k, illegal, e.cw, e.k, e.ill);
                end
            end
        end
    end

    task automatic push_mul4();
        for (int s = 0; s < 4; s++)
            sb_q.push_back(ex((s == 3) ? mk(2'b01, 5'd7, 5'd8, 5'd9, 5'b11000, 1'b1, 1'b1, 1'b0, 1'b0)
                                       : mk(2'b00, 5'd7, 5'd8, 5'd9, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0),
                              64'd0, 1'b0));
    endtask

    task automatic test_reset();
        reset_n = 1'b1;
        #1 reset_n = 1'b0;
        #1;
        n_checks++;
        if ({cw_valid, control_word, k, illegal, busy, instr_ready} !==
            {1'b0, 31'd0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state got v=%b cw=%h k=%h ill=%b busy=%b rdy=%b",
                     cw_valid, control_word, k, illegal, busy, instr_ready);
        end
        n_checks++;
        if ({r2_cw_valid, r2_cw, r2_k, r2_illegal, r2_busy, r2_ready} !==
            {1'b0, 31'd0, 32'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_state2 got v=%b cw=%h k=%h busy=%b rdy=%b",
                     r2_cw_valid, r2_cw, r2_k, r2_busy, r2_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_add();
        instr_valid = 1'b1;
        instruction = I_ADD;
        sb_q.push_back(ex(mk(2'b01, 5'd1, 5'd2, 5'd3, 5'b01000, 1'b1, 1'b1, 1'b0, 1'b0), 64'd0, 1'b0));
        @(negedge clock);
        instr_valid = 1'b0;
        n_checks++;
        if (cw_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL add_latency cw_valid got %b expected 1", cw_valid);
        end
        @(negedge clock);
        n_checks++;
        if (cw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL add_single_word cw_valid got %b expected 0", cw_valid);
        end
    endtask

    task automatic test_back_to_back();
        instr_valid = 1'b1;
        instruction = I_ADDI;
        sb_q.push_back(ex(mk(2'b01, 5'd5, 5'd6, 5'd0, 5'b01000, 1'b1, 1'b1, 1'b1, 1'b0), 64'd100, 1'b0));
        @(negedge clock);
        instruction = I_SUBS;
        sb_q.push_back(ex(mk(2'b01, 5'd0, 5'd1, 5'd2, 5'b01001, 1'b1, 1'b1, 1'b0, 1'b1), 64'd0, 1'b0));
        n_checks++;
        if ({cw_valid, instr_ready} !== 2'b11) begin
            n_fail++;
            $display("FAIL b2b_first v/rdy got %b%b expected 11", cw_valid, instr_ready);
        end
        @(negedge clock);
        instr_valid = 1'b0;
        n_checks++;
        if (cw_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_contiguous cw_valid got %b expected 1", cw_valid);
        end
        @(negedge clock);
        n_checks++;
        if (cw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end cw_valid got %b expected 0", cw_valid);
        end
    endtask

    task automatic test_mul();
        instr_valid = 1'b1;
        instruction = I_MUL;
        push_mul4();
        for (int s = 0; s < 4; s++) begin
            @(negedge clock);
            instruction = I_ORR;
            n_checks++;
            if ({cw_valid, busy, instr_ready} !== {1'b1, 1'b1, (s == 3)}) begin
                n_fail++;
                $display("FAIL mul_step%0d v/busy/rdy got %b%b%b expected 11%b",
                         s, cw_valid, busy, instr_ready, (s == 3));
            end
            if (s == 3)
                sb_q.push_back(ex(mk(2'b01, 5'd1, 5'd1, 5'd1, 5'b00100, 1'b1, 1'b1, 1'b0, 1'b0),
                                  64'd0, 1'b0));
        end
        @(negedge clock);
        instr_valid = 1'b0;
        n_checks++;
        if ({cw_valid, busy, instr_ready} !== 3'b101) begin
            n_fail++;
            $display("FAIL mul_followon v/busy/rdy got %b%b%b expected 101",
                     cw_valid, busy, instr_ready);
        end
        @(negedge clock);
        n_checks++;
        if (cw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mul_end cw_valid got %b expected 0", cw_valid);
        end
    endtask

    task automatic test_illegal();
        instr_valid = 1'b1;
        instruction = I_LDUR;
        sb_q.push_back(ex(31'h2000_0000, 64'd0, 1'b1));
        @(negedge clock);
        instr_valid = 1'b0;
        n_checks++;
        if (illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL illegal_pulse got %b expected 1", illegal);
        end
        @(negedge clock);
        n_checks++;
        if ({cw_valid, illegal} !== 2'b00) begin
            n_fail++;
            $display("FAIL illegal_one_cycle v/ill got %b%b expected 00", cw_valid, illegal);
        end
    endtask

    task automatic test_reset_mid_mul();
        instr_valid = 1'b1;
        instruction = I_MUL;
        push_mul4();
        @(negedge clock);
        instr_valid = 1'b0;
        @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        sb_q.delete();
        n_checks++;
        if ({cw_valid, control_word, k, illegal, busy, instr_ready} !==
            {1'b0, 31'd0, 64'd0, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_abort got v=%b cw=%h k=%h ill=%b busy=%b rdy=%b",
                     cw_valid, control_word, k, illegal, busy, instr_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            n_checks++;
            if ({cw_valid, busy, instr_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL post_reset_idle c%0d v/busy/rdy got %b%b%b expected 001",
                         c, cw_valid, busy, instr_ready);
            end
        end
    endtask

    task automatic test_mul_short();
        exp_t e;
        r2_valid = 1'b1;
        r2_instr = I_MUL;
        q2.push_back(ex(mk(2'b00, 5'd7, 5'd8, 5'd9, 5'b11000, 1'b0, 1'b0, 1'b0, 1'b0), 64'd0, 1'b0));
        q2.push_back(ex(mk(2'b01, 5'd7, 5'd8, 5'd9, 5'b11000, 1'b1, 1'b1, 1'b0, 1'b0), 64'd0, 1'b0));
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            n_checks++;
            if ({r2_busy, r2_ready} !== {(c < 2), (c > 0)}) begin
                n_fail++;
                $display("FAIL short_c%0d busy/rdy got %b%b expected %b%b",
                         c, r2_busy, r2_ready, (c < 2), (c > 0));
            end
            n_checks++;
            if (r2_cw_valid !== 1'b1 || q2.size() == 0) begin
                n_fail++;
                $display("FAIL short_word_c%0d cw_valid got %b expected 1 (pending %0d)",
                         c, r2_cw_valid, q2.size());
            end else begin
                e = q2.pop_front();
                if ({r2_cw, r2_k, r2_illegal} !== {e.cw, e.k[31:0], e.ill}) begin
                    n_fail++;
                    $display("FAIL short_word_c%0d got cw=%h k=%h expected cw=%h k=%h",
                             c, r2_cw, r2_k, e.cw, e.k[31:0]);
                end
            end
            if (c == 0) begin
                r2_instr = I_ADDIF;
                r2_valid = 1'b0;
            end else if (c == 1) begin
                r2_valid = 1'b1;
                q2.push_back(ex(mk(2'b01, 5'd0, 5'd0, 5'd0, 5'b01000, 1'b1, 1'b1, 1'b1, 1'b0),
                                64'h0000_0000_0000_0FFF, 1'b0));
            end else begin
                r2_valid = 1'b0;
            end
        end
        @(negedge clock);
        n_checks++;
        if (r2_cw_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL short_end cw_valid got %b expected 0", r2_cw_valid);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_illegal();
        test_reset_mid_mul();
        test_mul_short();
        @(negedge clock);
        n_checks++;
        if (sb_q.size() != 0 || q2.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain pending got %0d/%0d expected 0/0", sb_q.size(), q2.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
